// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
//   state_t        loader FSM states
//   SYNC_DEFAULT   default frame header byte
//   LEN_ZERO_BYTES image length encoded by a LEN byte of zero
//   last_index()   last write address for a LEN byte, clipped to the address space
package prog_loader_pkg;

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CKSUM, S_DONE, S_ERROR} state_t;

   localparam logic [7:0]  SYNC_DEFAULT   = 8'hA5;
   localparam int unsigned LEN_ZERO_BYTES = 256;

   // LEN-1 in 8-bit arithmetic maps LEN=0 onto 255 (256 bytes) for free;
   // the result is then capped so the final write lands on the top address.
   function automatic int unsigned last_index(input logic [7:0] len_byte, input int unsigned addr_w);
      logic [7:0]  m1;
      int unsigned cap;
      m1  = len_byte - 8'd1;
      cap = (addr_w >= 8) ? LEN_ZERO_BYTES - 32'd1 : (32'd1 << addr_w) - 32'd1;
      return (32'(m1) > cap) ? cap : 32'(m1);
   endfunction

endpackage

// File: rtl/prog_loader_cksum.sv
// prog_loader_cksum: mod-256 running sum of the frame payload.
//   clk, reset  clock, asynchronous active-high reset
//   clr         zero the sum (start of payload)
//   acc_en      add byte_in to the sum this cycle
//   byte_in     current host byte
//   sum         accumulated payload sum
//   zero        (sum + byte_in) mod 256 == 0, i.e. byte_in is a valid checksum
module prog_loader_cksum (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       acc_en,
   input  logic [7:0] byte_in,
   output logic [7:0] sum,
   output logic       zero
);

   logic [7:0] sum_q, sum_d, total;

   assign total = sum_q + byte_in;
   assign sum   = sum_q;
   assign zero  = total == 8'd0;

   always_comb sum_d = clr ? 8'd0 : acc_en ? total : sum_q;

   always_ff @(posedge clk or posedge reset)
      if (reset) sum_q <= 8'd0;
      else       sum_q <= sum_d;

endmodule

// File: rtl/program_loader.sv
// program_loader: framed byte-stream loader into program memory; holds the CPU in
// reset while a frame is in flight and releases it after a complete frame.
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_data      host byte stream, accepted when in_valid && in_ready
//   in_ready              loader can accept a byte
//   pm_wr_en/addr/data    registered program-memory write port
//   cpu_reset             hold-in-reset to the processor
//   busy / done / err     frame in progress / completion pulse / failed checksum
// Build option: define PROG_LOADER_CKSUM_EN to require and verify a trailing checksum byte.
module program_loader
   import prog_loader_pkg::*;
#(
   parameter int         ADDR_W    = 8,
   parameter int         DATA_W    = 8,
   parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              pm_wr_en,
   output logic [ADDR_W-1:0] pm_wr_addr,
   output logic [DATA_W-1:0] pm_wr_data,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d, last_q, last_d, pm_wr_addr_q, pm_wr_addr_d;
   logic [DATA_W-1:0] pm_wr_data_q, pm_wr_data_d;
   logic              pm_wr_en_q, pm_wr_en_d, cpu_reset_q, cpu_reset_d, in_ready_q, in_ready_d;
   logic              acc, wr, sum_ok;

   assign acc = in_valid && in_ready_q;
   assign wr  = state_q == S_DATA && acc;

`ifdef PROG_LOADER_CKSUM_EN
   localparam state_t AFTER_DATA = S_CKSUM;
   logic [7:0] unused_sum;
   prog_loader_cksum u_cksum (
      .clk     (clk),
      .reset   (reset),
      .clr     (state_q == S_LEN && acc),
      .acc_en  (wr),
      .byte_in (in_data),
      .sum     (unused_sum),
      .zero    (sum_ok)
   );
   assign err = state_q == S_ERROR;
`else
   localparam state_t AFTER_DATA = S_DONE;
   assign sum_ok = 1'b0;
   assign err    = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         last_q       <= '0;
         pm_wr_en_q   <= 1'b0;
         pm_wr_addr_q <= '0;
         pm_wr_data_q <= '0;
         cpu_reset_q  <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         last_q       <= last_d;
         pm_wr_en_q   <= pm_wr_en_d;
         pm_wr_addr_q <= pm_wr_addr_d;
         pm_wr_data_q <= pm_wr_data_d;
         cpu_reset_q  <= cpu_reset_d;
         in_ready_q   <= in_ready_d;
      end

   // A sync byte is only a header in IDLE/ERROR; mid-frame it is plain data.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_ERROR: if (acc && in_data == SYNC_BYTE) state_d = S_LEN;
         S_LEN:           if (acc) state_d = S_DATA;
         S_DATA:          if (acc && idx_q == last_q) state_d = AFTER_DATA;
         S_CKSUM:         if (acc) state_d = sum_ok ? S_DONE : S_ERROR;
         default:         state_d = S_IDLE;
      endcase
   end

   always_comb begin
      idx_d        = state_q == S_LEN ? '0 : wr ? idx_q + 1'b1 : idx_q;
      last_d       = (state_q == S_LEN && acc) ? ADDR_W'(last_index(in_data, ADDR_W)) : last_q;
      pm_wr_en_d   = wr;
      pm_wr_addr_d = wr ? idx_q : pm_wr_addr_q;
      pm_wr_data_d = wr ? DATA_W'(in_data) : pm_wr_data_q;
      cpu_reset_d  = state_d == S_LEN ? 1'b1 : state_d == S_DONE ? 1'b0 : cpu_reset_q;
      in_ready_d   = state_d != S_DONE;
   end

   assign in_ready   = in_ready_q;
   assign pm_wr_en   = pm_wr_en_q;
   assign pm_wr_addr = pm_wr_addr_q;
   assign pm_wr_data = pm_wr_data_q;
   assign cpu_reset  = cpu_reset_q;
   assign busy       = state_q inside {S_LEN, S_DATA, S_CKSUM};
   assign done       = state_q == S_DONE;

endmodule
